// File: rtl/crc16_stream_engine.sv
// crc16_stream_engine: streaming CRC-16 generator/checker over
// valid/ready beats, with partial last beat and framing checks.
module crc16_stream_engine #(
  parameter int          DATA_W = 72,
  parameter logic [15:0] POLY   = 16'h8005,
  parameter logic [15:0] INIT   = 16'h0000,
  parameter int          NB_W   = $clog2(DATA_W/8+1)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [NB_W-1:0]   in_nbytes,
  input  logic              check_en,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [15:0]       crc_out,
  output logic              crc_ok,
  output logic              err
);

  localparam int NBY = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [15:0]       crc;
  logic [15:0]       base;
  logic [15:0]       nxt;
  logic              mode;
  logic              rdy_en;
  logic              acc;
  logic              nb_bad;
  logic              frame_beat;
  logic [NB_W-1:0]   nb_eff;

  function automatic logic [15:0] crc_step(
    input logic [15:0]       c,
    input logic [DATA_W-1:0] d,
    input logic [NB_W-1:0]   n
  );
    logic [15:0] r;
    logic        fb;
    r  = c;
    fb = 1'b0;
    for (int i = 0; i < NBY; i++) begin
      if (i < int'(n)) begin
        for (int b = 0; b < 8; b++) begin
          fb = r[15] ^ d[DATA_W-1-8*i-b];
          r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
      end
    end
    return r;
  endfunction

  // rdy_en keeps in_ready low through reset and the first cycle after
  assign in_ready = rdy_en & ((state != DONE) | crc_ready);
  assign acc      = in_valid & in_ready;

  // a beat joins a frame if it opens one or continues a busy one
  assign frame_beat = in_sop | (state == BUSY);

  always_comb begin
    nb_bad = in_eop &
      ((in_nbytes == '0) | (in_nbytes > NB_W'(NBY)));
    nb_eff = (!in_eop || nb_bad) ? NB_W'(NBY) : in_nbytes;
    base   = in_sop ? INIT : crc;
    nxt    = crc_step(base, in_data, nb_eff);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= IDLE;
      crc       <= INIT;
      mode      <= 1'b0;
      rdy_en    <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= 16'h0000;
      crc_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      err    <= 1'b0;
      if (state == DONE && crc_ready) begin
        crc_valid <= 1'b0;
        state     <= IDLE;
      end
      if (acc) begin
        if (frame_beat) begin
          err <= ((state == BUSY) & in_sop) | nb_bad;
          crc <= nxt;
          if (in_sop) begin
            mode <= check_en;
          end
          if (in_eop) begin
            state     <= DONE;
            crc_valid <= 1'b1;
            crc_out   <= nxt;
            crc_ok    <= (in_sop ? check_en : mode) &
                         (nxt == 16'h0000);
          end else begin
            state <= BUSY;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
